hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed W-stage GRF forwarding decoder.
- Tracks in-flight register writes from E to the last stage. Each write carries a Tnew countdown.
- From that state it produces, for every decode-stage read port, a stall request and a forwarding source select.
- Sits beside the D-stage register file and drives the D/E pipeline control and the bypass muxes.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_port_check.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding source encodings and
// the Tnew/Tuse guide values for each instruction class.
package hazard_pkg;

    localparam int unsigned FWD_GRF = 0;
    localparam int unsigned FWD_E   = 1;
    localparam int unsigned FWD_M   = 2;
    localparam int unsigned FWD_W   = 3;

    // Cycles after entering E until the result can be forwarded.
    localparam int unsigned TNEW_ALU  = 1;
    localparam int unsigned TNEW_LOAD = 2;
    localparam int unsigned TNEW_LINK = 0;

    // Cycles from D until the operand is consumed.
    localparam int unsigned TUSE_BRANCH = 0;
    localparam int unsigned TUSE_ALU    = 1;
    localparam int unsigned TUSE_STORE  = 2;

endpackage

// File: rtl/hazard_port_check.sv
// Per-read-port youngest-match search producing forward select, ready and stall term.
// GRF_BYPASS_EN: a youngest match in the last stage is served by the write-through GRF.
module hazard_port_check
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [TNEW_W-1:0]         rd_tuse,
    input  logic [DEPTH-1:0]          st_valid,
    input  logic [DEPTH*ADDR_W-1:0]   st_addr,
    input  logic [DEPTH*TNEW_W-1:0]   st_tnew,
    output logic [SEL_W-1:0]          sel,
    output logic                      rdy,
    output logic                      stall_req
);

    logic              hit;
    logic [SEL_W-1:0]  hit_k;
    logic [TNEW_W-1:0] hit_tnew;

    always_comb begin
        // NOTE: every output gets a default before any condition, so no latch is inferred.
        hit      = 1'b0;
        hit_k    = '0;
        hit_tnew = '0;
        // Oldest to youngest, so the last assignment is the youngest match.
        for (int k = DEPTH; k >= 1; k--) begin
            if (rd_en && (rd_addr != '0) && st_valid[k-1] &&
                (st_addr[(k-1)*ADDR_W +: ADDR_W] == rd_addr)) begin
                hit      = 1'b1;
                hit_k    = SEL_W'(k);
                hit_tnew = st_tnew[(k-1)*TNEW_W +: TNEW_W];
            end
        end
    end

    always_comb begin
        sel = SEL_W'(FWD_GRF);
        rdy = 1'b1;
        if (hit) begin
            sel = hit_k;
            rdy = (hit_tnew == '0);
        end
`ifdef GRF_BYPASS_EN
        if (hit && (hit_k == SEL_W'(DEPTH))) begin
            sel = SEL_W'(FWD_GRF);
            rdy = 1'b1;
        end
`endif
    end

    assign stall_req = hit && (hit_tnew > rd_tuse);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes from E to the last stage and drives D-stage stall/forwarding.
// GRF_BYPASS_EN: define when the register file is write-through (last-stage matches read the GRF).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int DEPTH        = 3,
    parameter int ADDR_W       = 5,
    parameter int TNEW_W       = 2,
    parameter int CNT_W        = 32,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD_PORTS-1:0]        rd_en,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD_PORTS*TNEW_W-1:0] rd_tuse,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [TNEW_W-1:0]              wr_tnew,
    input  logic                           flush,
    output logic                           stall,
    output logic [NUM_RD_PORTS*SEL_W-1:0]  fwd_sel,
    output logic [NUM_RD_PORTS-1:0]        fwd_rdy,
    output logic [CNT_W-1:0]               stall_cnt
);

    // Entry index k-1 holds stage k (index 0 is E, index DEPTH-1 is the last stage).
    logic [DEPTH-1:0]        st_valid, nxt_valid;
    logic [DEPTH*ADDR_W-1:0] st_addr,  nxt_addr;
    logic [DEPTH*TNEW_W-1:0] st_tnew,  nxt_tnew;
    logic [NUM_RD_PORTS-1:0] port_stall;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        hazard_port_check #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .TNEW_W (TNEW_W),
            .SEL_W  (SEL_W)
        ) u_port_check (
            .rd_en     (rd_en[p]),
            .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
            .rd_tuse   (rd_tuse[p*TNEW_W +: TNEW_W]),
            .st_valid  (st_valid),
            .st_addr   (st_addr),
            .st_tnew   (st_tnew),
            .sel       (fwd_sel[p*SEL_W +: SEL_W]),
            .rdy       (fwd_rdy[p]),
            .stall_req (port_stall[p])
        );
    end

    assign stall = |port_stall;

    always_comb begin
        nxt_valid = st_valid;
        nxt_addr  = st_addr;
        nxt_tnew  = st_tnew;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            nxt_valid[k]                 = st_valid[k-1];
            nxt_addr[k*ADDR_W +: ADDR_W] = st_addr[(k-1)*ADDR_W +: ADDR_W];
            nxt_tnew[k*TNEW_W +: TNEW_W] =
                (st_tnew[(k-1)*TNEW_W +: TNEW_W] == '0) ? '0 :
                st_tnew[(k-1)*TNEW_W +: TNEW_W] - TNEW_W'(1);
        end
        // A stalled or flushed D instruction enters E as a single bubble.
        if (stall || flush) begin
            nxt_valid[0]        = 1'b0;
            nxt_addr[ADDR_W-1:0] = '0;
            nxt_tnew[TNEW_W-1:0] = '0;
        end else begin
            nxt_valid[0]        = wr_en && (wr_addr != '0);
            nxt_addr[ADDR_W-1:0] = wr_addr;
            nxt_tnew[TNEW_W-1:0] = wr_tnew;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_valid  <= '0;
            st_addr   <= '0;
            st_tnew   <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every entry shifts from the pre-edge state.
            st_valid <= nxt_valid;
            st_addr  <= nxt_addr;
            st_tnew  <= nxt_tnew;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard; expected outputs are queued at drive time
// and compared when sampled. A second instance with a 2-bit counter checks saturation.
module tb_hazard_scoreboard;

    localparam int NP = 2;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam int SW = 2;
`ifdef GRF_BYPASS_EN
    localparam logic [1:0] W_SEL = 2'd0;
`else
    localparam logic [1:0] W_SEL = 2'd3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*TW-1:0] rd_tuse;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [TW-1:0]    wr_tnew;
    logic             flush;
    logic             stall, stall_s;
    logic [NP*SW-1:0] fwd_sel, fwd_sel_s;
    logic [NP-1:0]    fwd_rdy, fwd_rdy_s;
    logic [31:0]      stall_cnt;
    logic [1:0]       stall_cnt_s;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_RD_PORTS(NP), .DEPTH(3), .ADDR_W(AW), .TNEW_W(TW), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_tuse(rd_tuse),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tnew(wr_tnew), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel), .fwd_rdy(fwd_rdy), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(
        .NUM_RD_PORTS(NP), .DEPTH(3), .ADDR_W(AW), .TNEW_W(TW), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_tuse(rd_tuse),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tnew(wr_tnew), .flush(flush),
        .stall(stall_s), .fwd_sel(fwd_sel_s), .fwd_rdy(fwd_rdy_s), .stall_cnt(stall_cnt_s)
    );

    typedef struct {
        string       tag;
        logic        stall;
        logic [1:0]  sel0;
        logic        rdy0;
        logic [1:0]  sel1;
        logic        rdy1;
        logic [31:0] cnt;
        bit          chk_rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en   = '0;
        rd_addr = '0;
        rd_tuse = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_tnew = '0;
        flush   = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input int p, input int a, input int t);
        rd_en[p]            = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
        rd_tuse[p*TW +: TW] = TW'(t);
    endtask

    task automatic wr(input int a, input int t);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_tnew = TW'(t);
    endtask

    task automatic expect_out(input string tag, input logic st,
                              input logic [1:0] s0, input logic r0,
                              input logic [1:0] s1, input logic r1,
                              input int cnt, input bit chk_rdy = 1'b1);
        exp_t e;
        logic [31:0] cnt_sat;
        e = '{tag, st, s0, r0, s1, r1, 32'(cnt), chk_rdy};
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        cnt_sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        check({e.tag, ".stall"}, stall, e.stall);
        check({e.tag, ".sel0"}, fwd_sel[1:0], e.sel0);
        check({e.tag, ".sel1"}, fwd_sel[3:2], e.sel1);
        check({e.tag, ".cnt"}, stall_cnt, e.cnt);
        check({e.tag, ".stall_s"}, stall_s, e.stall);
        check({e.tag, ".sel_s"}, fwd_sel_s, {e.sel1, e.sel0});
        check({e.tag, ".cnt_sat"}, stall_cnt_s, cnt_sat);
        if (e.chk_rdy) begin
            check({e.tag, ".rdy0"}, fwd_rdy[0], e.rdy0);
            check({e.tag, ".rdy1"}, fwd_rdy[1], e.rdy1);
            check({e.tag, ".rdy_s"}, fwd_rdy_s, {e.rdy1, e.rdy0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        rd_en   = 2'b11;
        rd_addr = 10'($urandom);
        rd_tuse = 4'($urandom);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_tnew = 2'd3;
        flush   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(); reset = 1'b1; rd(0, 5, 0); rd(1, 5, 0);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 1'b0);

        // ALU then dependent ALU, through to retirement
        step(); wr(8, 1);     expect_out("alu_c0", 0, 0, 1, 0, 1, 0);
        step(); rd(0, 8, 1);  expect_out("alu_c1", 0, 1, 0, 0, 1, 0);
        step(); rd(0, 8, 1);  expect_out("alu_c2", 0, 2, 1, 0, 1, 0);
        step(); rd(0, 8, 1);  expect_out("alu_w", 0, W_SEL, 1, 0, 1, 0);
        step(); rd(0, 8, 1);  expect_out("alu_retired", 0, 0, 1, 0, 1, 0);

        // Load-use: the stalled reader's own write must not enter E while stalled
        step(); wr(9, 2);                   expect_out("ld_c0", 0, 0, 1, 0, 1, 0);
        step(); rd(0, 9, 1); wr(10, 1);     expect_out("ld_use", 1, 1, 0, 0, 1, 0);
        step(); rd(0, 9, 1); wr(10, 1);     expect_out("ld_after", 0, 2, 0, 0, 1, 1);
        step(); rd(0, 9, 1); rd(1, 10, 1);  expect_out("ld_w", 0, W_SEL, 1, 1, 0, 1);
        step(); rd(1, 10, 2);               expect_out("store_m", 0, 0, 1, 2, 1, 1);

        // Branch after load: two stall cycles
        step(); wr(9, 2);     expect_out("br_c0", 0, 0, 1, 0, 1, 1);
        step(); rd(0, 9, 0);  expect_out("br_s1", 1, 1, 0, 0, 1, 1);
        step(); rd(0, 9, 0);  expect_out("br_s2", 1, 2, 0, 0, 1, 2);
        step(); rd(0, 9, 0);  expect_out("br_go", 0, W_SEL, 1, 0, 1, 3);

        // Youngest match wins; register 0 never tracked
        step(); wr(4, 1);     expect_out("pri_c0", 0, 0, 1, 0, 1, 3);
        step(); wr(4, 0);     expect_out("pri_c1", 0, 0, 1, 0, 1, 3);
        step(); rd(1, 4, 1); rd(0, 0, 0); wr(0, 1);
        expect_out("pri_young", 0, 0, 1, 1, 1, 3);
        step(); rd(0, 4, 0); rd(1, 0, 0);
        expect_out("pri_r0", 0, 2, 1, 0, 1, 3);

        // flush and stall together: one bubble, counter +1
        step(); wr(11, 2);    expect_out("fs_c0", 0, 0, 1, 0, 1, 3);
        step(); wr(12, 1); rd(0, 11, 1); flush = 1'b1;
        expect_out("fs_both", 1, 1, 0, 0, 1, 3);
        step(); rd(0, 11, 1); rd(1, 12, 0);
        expect_out("fs_after", 0, 2, 0, 0, 1, 4);

        // flush alone drops the D write
        step(); wr(13, 1); flush = 1'b1; rd(0, 11, 1);
        expect_out("fl_only", 0, W_SEL, 1, 0, 1, 4);
        step(); rd(1, 13, 0); expect_out("fl_after", 0, 0, 1, 0, 1, 4);

        // Reset asserted mid-stall
        step(); wr(14, 2);    expect_out("rs_c0", 0, 0, 1, 0, 1, 4);
        step(); rd(0, 14, 0); expect_out("rs_s1", 1, 1, 0, 0, 1, 4);
        step(); rd(0, 14, 0); reset = 1'b0;
        expect_out("rs_s2", 1, 2, 0, 0, 1, 5);
        step(); reset = 1'b1; rd(0, 14, 0);
        expect_out("rs_after", 0, 0, 1, 0, 1, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
